// File: rtl/ins_queue_pkg.sv
// Shared types and sizing for the instruction queue between IFetcher and Issue.
package ins_queue_pkg;
  localparam int XLEN       = 32;
  localparam int INSQ_SIZE  = 16;
  localparam int INSQ_SLACK = 2;

  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic            jump_flag;
    logic [XLEN-1:0] jump_pc;
  } insq_entry_t;
endpackage

// File: rtl/ins_queue_if.sv
// IFetcher-push / Issue-pop signal bundle for ins_queue.
interface ins_queue_if;
  import ins_queue_pkg::*;

  logic            IF_sgn;
  logic [XLEN-1:0] IF_ins;
  logic            IF_jump_flag;
  logic [XLEN-1:0] IF_jump_pc;
  logic            IF_full;
  logic            IS_sgn;
  logic [XLEN-1:0] IS_ins;
  logic            IS_jump_flag;
  logic [XLEN-1:0] IS_jump_pc;
  logic            IS_pop;

  modport master (
    output IF_sgn, IF_ins, IF_jump_flag, IF_jump_pc, IS_pop,
    input  IF_full, IS_sgn, IS_ins, IS_jump_flag, IS_jump_pc
  );

  modport slave (
    input  IF_sgn, IF_ins, IF_jump_flag, IF_jump_pc, IS_pop,
    output IF_full, IS_sgn, IS_ins, IS_jump_flag, IS_jump_pc
  );
endinterface

// File: rtl/ins_queue.sv
// Instruction FIFO with misprediction flush and almost-full backpressure.
// Head outputs are read straight from storage; no write-through on empty.
module ins_queue
  import ins_queue_pkg::*;
#(
  parameter int DEPTH = INSQ_SIZE,
  parameter int SLACK = INSQ_SLACK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       jp_wrong,
  ins_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HIWAT    = CW'(DEPTH - SLACK);

  insq_entry_t   mem_q [DEPTH];
  insq_entry_t   wr_ent, head_ent;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty, push, pop;

  assign empty = (count_q == '0);
  // Full check uses registered count only: a pop in the same cycle does not free a slot.
  assign push  = rdy && !jp_wrong && q.IF_sgn && (count_q != FULL_CNT);
  assign pop   = rdy && !jp_wrong && q.IS_pop && !empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy) begin
      if (jp_wrong) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) tail_d = tail_q + PW'(1);
        if (pop)  head_d = head_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    wr_ent           = '0;
    wr_ent.ins       = q.IF_ins;
    wr_ent.jump_flag = q.IF_jump_flag;
    wr_ent.jump_pc   = q.IF_jump_pc;
  end

  // Storage is deliberately left uncleared on reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= wr_ent;
  end

  assign head_ent       = mem_q[head_q];
  assign q.IS_sgn       = !empty;
  assign q.IS_ins       = empty ? '0   : head_ent.ins;
  assign q.IS_jump_flag = empty ? 1'b0 : head_ent.jump_flag;
  assign q.IS_jump_pc   = empty ? '0   : head_ent.jump_pc;
  assign q.IF_full      = (count_q >= HIWAT);
endmodule

// File: tb/tb_ins_queue.sv
// Directed bench for ins_queue with a queue-based reference model checked every cycle.
module tb_ins_queue;
  import ins_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int SLACK = 2;

  logic clk = 1'b0;
  logic rst, rdy, jp_wrong;
  int   n_chk = 0;
  int   n_fail = 0;

  ins_queue_if qif ();

  ins_queue #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .jp_wrong (jp_wrong),
    .q        (qif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of entries updated by the queue rules.
  insq_entry_t mq[$];

  always @(posedge clk or posedge rst) begin
    if (rst) mq.delete();
    else if (rdy) begin
      if (jp_wrong) mq.delete();
      else begin
        automatic bit do_pop  = qif.IS_pop && (mq.size() != 0);
        automatic bit do_push = qif.IF_sgn && (mq.size() < DEPTH);
        automatic insq_entry_t e;
        e.ins = qif.IF_ins; e.jump_flag = qif.IF_jump_flag; e.jump_pc = qif.IF_jump_pc;
        if (do_pop)  mq.delete(0);
        if (do_push) mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    automatic insq_entry_t h = '0;
    if (mq.size() != 0) h = mq[0];
    chk("m_sgn",  qif.IS_sgn,       mq.size() != 0);
    chk("m_ins",  qif.IS_ins,       h.ins);
    chk("m_flag", qif.IS_jump_flag, h.jump_flag);
    chk("m_pc",   qif.IS_jump_pc,   h.jump_pc);
    chk("m_full", qif.IF_full,      mq.size() >= DEPTH - SLACK);
  end

  task automatic step(input logic sgn, input logic [31:0] ins, input logic pop,
                      input logic jw = 1'b0, input logic r = 1'b1,
                      input logic fl = 1'b0, input logic [31:0] pc = 32'h0);
    qif.IF_sgn = sgn; qif.IF_ins = ins; qif.IF_jump_flag = fl; qif.IF_jump_pc = pc;
    qif.IS_pop = pop; jp_wrong = jw; rdy = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] ins);
    step(1'b1, ins, 1'b0);
  endtask

  task automatic pop1();
    step(1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; jp_wrong = 1'b0;
    qif.IF_sgn = 1'b0; qif.IF_ins = '0; qif.IF_jump_flag = 1'b0;
    qif.IF_jump_pc = '0; qif.IS_pop = 1'b0;
    @(negedge clk);
    chk("rst_sgn",  qif.IS_sgn,  1'b0);
    chk("rst_ins",  qif.IS_ins,  32'h0);
    chk("rst_full", qif.IF_full, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // basic order and 1-cycle latency
    push(32'h00000013);
    chk("lat_sgn", qif.IS_sgn, 1'b1);
    chk("lat_ins", qif.IS_ins, 32'h00000013);
    push(32'h00100093);
    push(32'h00200113);
    chk("ord0", qif.IS_ins, 32'h00000013); pop1();
    chk("ord1", qif.IS_ins, 32'h00100093); pop1();
    chk("ord2", qif.IS_ins, 32'h00200113); pop1();
    chk("ord_empty", qif.IS_sgn, 1'b0);

    // fill to full, overflow push dropped
    for (int i = 0; i < 14; i++) begin
      push(32'h100 + i);
      if (i == 12) chk("full_13", qif.IF_full, 1'b0);
    end
    chk("full_14", qif.IF_full, 1'b1);
    push(32'h10E); push(32'h10F);
    chk("cnt16", mq.size(), 16);
    push(32'hDEADBEEF);
    chk("cnt16_drop", mq.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("full_ord", qif.IS_ins, 32'h100 + i);
      pop1();
    end
    chk("full_empty", qif.IS_sgn, 1'b0);

    // simultaneous push and pop at count 5
    for (int i = 0; i < 5; i++) push(32'h200 + i);
    step(1'b1, 32'h2FF, 1'b1);
    chk("pp5_cnt", mq.size(), 5);
    chk("pp5_head", qif.IS_ins, 32'h201);
    for (int i = 1; i < 5; i++) begin
      chk("pp5_ord", qif.IS_ins, 32'h200 + i);
      pop1();
    end
    chk("pp5_last", qif.IS_ins, 32'h2FF);
    pop1();

    // simultaneous at full: push rejected
    for (int i = 0; i < 16; i++) push(32'h300 + i);
    step(1'b1, 32'hBAD0BAD0, 1'b1);
    chk("pp16_cnt", mq.size(), 15);
    chk("pp16_head", qif.IS_ins, 32'h301);
    chk("pp16_full", qif.IF_full, 1'b1);
    for (int i = 1; i < 16; i++) begin
      chk("pp16_ord", qif.IS_ins, 32'h300 + i);
      pop1();
    end
    chk("pp16_empty", qif.IS_sgn, 1'b0);

    // simultaneous at empty: pop ignored
    step(1'b1, 32'h400, 1'b1);
    chk("pp0_cnt", mq.size(), 1);
    chk("pp0_sgn", qif.IS_sgn, 1'b1);
    chk("pp0_ins", qif.IS_ins, 32'h400);
    pop1();

    // flush beats push and pop
    for (int i = 0; i < 7; i++) push(32'h500 + i);
    step(1'b1, 32'h555, 1'b1, 1'b1);
    chk("fl_sgn", qif.IS_sgn, 1'b0);
    chk("fl_cnt", mq.size(), 0);
    step(1'b1, 32'h00000067, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000);
    chk("tag_ins",  qif.IS_ins,       32'h00000067);
    chk("tag_flag", qif.IS_jump_flag, 1'b1);
    chk("tag_pc",   qif.IS_jump_pc,   32'h1000);
    pop1();

    // rdy low freezes everything
    for (int i = 0; i < 3; i++) push(32'h700 + i);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h777, 1'b1, 1'b1, 1'b0);
    chk("rdy_cnt", mq.size(), 3);
    chk("rdy_ins", qif.IS_ins, 32'h700);
    pop1();
    chk("rdy_resume", qif.IS_ins, 32'h701);
    pop1(); pop1();
    chk("rdy_empty", qif.IS_sgn, 1'b0);

    // pointer wrap: pops lag pushes by 2 cycles
    for (int c = 0; c < 42; c++) begin
      if (c >= 2) chk("wrap_ord", qif.IS_ins, 32'h800 + c - 2);
      step(c < 40, 32'h800 + c, c >= 2);
    end
    chk("wrap_empty", qif.IS_sgn, 1'b0);

    // async reset mid-cycle with rdy low
    for (int i = 0; i < 15; i++) push(32'h900 + i);
    chk("pre_rst_full", qif.IF_full, 1'b1);
    qif.IF_sgn = 1'b0; qif.IS_pop = 1'b0; rdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_sgn",  qif.IS_sgn,  1'b0);
    chk("arst_ins",  qif.IS_ins,  32'h0);
    chk("arst_full", qif.IF_full, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    chk("post_rst_sgn", qif.IS_sgn, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
